// File: rtl/cordic_panel_ctrl.sv
// cordic_panel_ctrl
//   Board-level controller for the CORDIC demonstrator. Conditions the two
//   active-low push-buttons (2-flop synchroniser + debouncer + press
//   detector), launches the external cordic_prop core with a one-cycle start,
//   waits for its done with a timeout, latches cos/sin and drives the value
//   selected for the 7-segment path.
//
// Ports
//   clk_50, reset         : clock, synchronous active-high reset
//   start_n, mode_n       : raw active-low buttons (asynchronous)
//   angle                 : unsigned angle from switches
//   cordic_start          : one-cycle launch pulse to the core
//   cordic_z0             : angle captured at launch, stable until next launch
//   cordic_done           : core completion (level or pulse)
//   cordic_cos/cordic_sin : signed core results
//   display_number        : registered signed value for the display
//   display_sel           : 0 angle, 1 cos, 2 sin
//   busy, result_valid    : run in flight / latched results are from a completed run
//   fault                 : sticky timeout flag, cleared by the next accepted Start
//   dbg_state_o           : current FSM state (0 IDLE, 1 START, 2 WAIT)
//
// Core handshake: cordic_start is a single-cycle request with cordic_z0 valid
// in the same cycle; there is no backpressure. The core answers by raising
// cordic_done (any length); only the first done cycle seen in WAIT is used,
// and done outside WAIT is ignored.
module cordic_panel_ctrl #(
  parameter int ANGLE_W         = 9,
  parameter int OUT_W           = 11,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                    clk_50,
  input  logic                    reset,
  input  logic                    start_n,
  input  logic                    mode_n,
  input  logic [ANGLE_W-1:0]      angle,
  output logic                    cordic_start,
  output logic [ANGLE_W-1:0]      cordic_z0,
  input  logic                    cordic_done,
  input  logic signed [OUT_W-1:0] cordic_cos,
  input  logic signed [OUT_W-1:0] cordic_sin,
  output logic [OUT_W-1:0]        display_number,
  output logic [1:0]              display_sel,
  output logic                    busy,
  output logic                    result_valid,
  output logic                    fault,
  output logic [1:0]              dbg_state_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning, bit 0 = Start, bit 1 = Mode. All levels idle at 1.
  // ---------------------------------------------------------------------------
  logic [1:0]      sync1_q, sync2_q, db_q, db_prev_q;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [1:0]      press;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      db_q      <= 2'b11;
      db_prev_q <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= {mode_n, start_n};
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        // Count consecutive samples that disagree with the accepted level;
        // the level flips on the DEBOUNCE_CYCLES-th one, any agreement restarts.
        if (sync2_q[i] != db_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            db_q[i]     <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // Falling edge of the debounced level only: release and hold give nothing.
  assign press = db_prev_q & ~db_q;

  // ---------------------------------------------------------------------------
  // Run FSM and result / display registers
  // ---------------------------------------------------------------------------
  state_t                   state_q, state_d;
  logic [TO_W-1:0]          wait_cnt_q, wait_cnt_d;
  logic [ANGLE_W-1:0]       z0_q, z0_d;
  logic signed [OUT_W-1:0]  cos_q, cos_d, sin_q, sin_d;
  logic                     rv_q, rv_d, fault_q, fault_d;
  logic [1:0]               sel_q, sel_d;
  logic [OUT_W-1:0]         disp_q, disp_d;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      z0_q       <= '0;
      cos_q      <= '0;
      sin_q      <= '0;
      rv_q       <= 1'b0;
      fault_q    <= 1'b0;
      sel_q      <= 2'd0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      z0_q       <= z0_d;
      cos_q      <= cos_d;
      sin_q      <= sin_d;
      rv_q       <= rv_d;
      fault_q    <= fault_d;
      sel_q      <= sel_d;
      disp_q     <= disp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    z0_d       = z0_q;
    cos_d      = cos_q;
    sin_d      = sin_q;
    rv_d       = rv_q;
    fault_d    = fault_q;
    sel_d      = sel_q;
    disp_d     = disp_q;

    unique case (state_q)
      S_IDLE: begin
        if (press[0]) begin
          z0_d    = angle;
          fault_d = 1'b0;
          rv_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // Done wins over a timeout falling in the same cycle.
        if (cordic_done) begin
          cos_d   = cordic_cos;
          sin_d   = cordic_sin;
          rv_d    = 1'b1;
          state_d = S_IDLE;
        end else if (wait_cnt_q == TO_LAST) begin
          fault_d = 1'b1;
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (press[1]) sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;

    // Driven from registered selector/data, so the display lags them by one cycle.
    case (sel_q)
      2'd0:    disp_d = {{(OUT_W-ANGLE_W){1'b0}}, z0_q};
      2'd1:    disp_d = cos_q;
      default: disp_d = sin_q;
    endcase
  end

  assign cordic_start   = (state_q == S_START);
  assign busy           = (state_q != S_IDLE);
  assign cordic_z0      = z0_q;
  assign display_number = disp_q;
  assign display_sel    = sel_q;
  assign result_valid   = rv_q;
  assign fault          = fault_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_cordic_panel_ctrl.sv
// Directed bench for cordic_panel_ctrl with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16.
// A small behavioural core model answers cordic_start after a programmable
// latency; a monitor counts cordic_start pulses and records cordic_z0.
module tb_cordic_panel_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start_n = 1'b1;
  logic        mode_n = 1'b1;
  logic [8:0]  angle = '0;
  logic        cordic_start;
  logic [8:0]  cordic_z0;
  wire         cordic_done;
  logic [10:0] cordic_cos = '0;
  logic [10:0] cordic_sin = '0;
  logic [10:0] display_number;
  logic [1:0]  display_sel;
  logic        busy, result_valid, fault;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // core model
  logic        model_en = 1'b0;
  int          model_lat = 3;
  logic [10:0] model_cos = '0;
  logic [10:0] model_sin = '0;
  int          model_cnt = 0;
  logic        model_done = 1'b0;
  logic        man_done = 1'b0;
  assign cordic_done = model_done | man_done;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (model_cnt == 1) begin
      model_done <= 1'b1;
      cordic_cos <= model_cos;
      cordic_sin <= model_sin;
    end
    if (cordic_start === 1'b1 && model_en) model_cnt <= model_lat;
    else if (model_cnt != 0) model_cnt <= model_cnt - 1;
  end

  // start monitor
  int         n_starts = 0;
  logic [8:0] last_z0 = '0;
  always @(posedge clk) begin
    if (cordic_start === 1'b1) begin
      n_starts <= n_starts + 1;
      last_z0  <= cordic_z0;
    end
  end

  cordic_panel_ctrl #(
    .ANGLE_W(9), .OUT_W(11), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_50(clk), .reset(reset), .start_n(start_n), .mode_n(mode_n),
    .angle(angle), .cordic_start(cordic_start), .cordic_z0(cordic_z0),
    .cordic_done(cordic_done), .cordic_cos(cordic_cos), .cordic_sin(cordic_sin),
    .display_number(display_number), .display_sel(display_sel), .busy(busy),
    .result_valid(result_valid), .fault(fault), .dbg_state_o(dbg_state)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start(input int hold);
    start_n = 1'b0;
    cyc(hold);
    start_n = 1'b1;
  endtask

  task automatic press_mode();
    mode_n = 1'b0;
    cyc(8);
    mode_n = 1'b1;
    cyc(10);
  endtask

  // Waits (bounded) for the negedge on which cordic_start is high.
  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cordic_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; angle = 9'd123;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    @(negedge clk);
    checks++; if (cordic_start !== 1'b0) begin errors++; $display("FAIL reset_start got %0b exp 0", cordic_start); end
    checks++; if (cordic_z0 !== 9'd0) begin errors++; $display("FAIL reset_z0 got %0d exp 0", cordic_z0); end
    checks++; if (display_number !== 11'd0) begin errors++; $display("FAIL reset_disp got %0d exp 0", display_number); end
    checks++; if (display_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", display_sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %0b exp 0", result_valid); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b exp 0", fault); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_basic();
    int s0;
    s0 = n_starts;
    angle = 9'd90; model_en = 1'b1; model_lat = 3; model_cos = 11'd0; model_sin = 11'd511;
    press_start(10);
    cyc(20);
    @(negedge clk);
    checks++; if (n_starts - s0 !== 1) begin errors++; $display("FAIL basic_nstart got %0d exp 1", n_starts - s0); end
    checks++; if (last_z0 !== 9'd90) begin errors++; $display("FAIL basic_z0 got %0d exp 90", last_z0); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL basic_rv got %0b exp 1", result_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %0b exp 0", busy); end
    checks++; if (display_number !== 11'd90) begin errors++; $display("FAIL basic_disp0 got %0d exp 90", display_number); end
    press_mode(); @(negedge clk);
    checks++; if (display_sel !== 2'd1) begin errors++; $display("FAIL basic_sel1 got %0d exp 1", display_sel); end
    checks++; if (display_number !== 11'd0) begin errors++; $display("FAIL basic_cos got %0d exp 0", display_number); end
    press_mode(); @(negedge clk);
    checks++; if (display_sel !== 2'd2) begin errors++; $display("FAIL basic_sel2 got %0d exp 2", display_sel); end
    checks++; if (display_number !== 11'd511) begin errors++; $display("FAIL basic_sin got %0d exp 511", display_number); end
    press_mode(); @(negedge clk);
    checks++; if (display_sel !== 2'd0) begin errors++; $display("FAIL basic_wrap got %0d exp 0", display_sel); end
    checks++; if (display_number !== 11'd90) begin errors++; $display("FAIL basic_wrap_disp got %0d exp 90", display_number); end
  endtask

  task automatic test_bounce();
    int s0;
    s0 = n_starts;
    for (int i = 0; i < 10; i++) begin
      start_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      cyc(2);
    end
    start_n = 1'b1;
    cyc(20);
    @(negedge clk);
    checks++; if (n_starts - s0 !== 0) begin errors++; $display("FAIL bounce_nstart got %0d exp 0", n_starts - s0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bounce_busy got %0b exp 0", busy); end
  endtask

  task automatic test_timeout();
    bit found;
    int n;
    model_en = 1'b0; angle = 9'd200;
    press_start(6);
    wait_start(found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL to_start_seen got %0b exp 1", found); end
    checks++; if (cordic_z0 !== 9'd200) begin errors++; $display("FAIL to_z0 got %0d exp 200", cordic_z0); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL to_rv_clear got %0b exp 0", result_valid); end
    n = 0;
    for (int i = 0; i < 40 && fault !== 1'b1; i++) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 17) begin errors++; $display("FAIL to_latency got %0d exp 17", n); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL to_fault got %0b exp 1", fault); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy got %0b exp 0", busy); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL to_rv got %0b exp 0", result_valid); end
    cyc(1);
    press_mode(); press_mode(); @(negedge clk);
    checks++; if (display_number !== 11'd511) begin errors++; $display("FAIL to_sin_kept got %0d exp 511", display_number); end
    press_mode(); @(negedge clk);
    checks++; if (display_number !== 11'd200) begin errors++; $display("FAIL to_disp_z0 got %0d exp 200", display_number); end

    // recovery with a working core
    model_en = 1'b1; model_lat = 3; model_cos = 11'd100; model_sin = 11'd200; angle = 9'd45;
    cyc(1);
    press_start(6);
    wait_start(found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rec_start_seen got %0b exp 1", found); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rec_fault_clear got %0b exp 0", fault); end
    cyc(15);
    @(negedge clk);
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL rec_rv got %0b exp 1", result_valid); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rec_fault got %0b exp 0", fault); end
    checks++; if (display_number !== 11'd45) begin errors++; $display("FAIL rec_disp got %0d exp 45", display_number); end
  endtask

  task automatic test_busy_lockout();
    int s0;
    logic [10:0] exp_cos, exp_sin;
    exp_cos = -11'sd300;
    exp_sin = -11'sd5;
    s0 = n_starts;
    model_en = 1'b1; model_lat = 13; model_cos = exp_cos; model_sin = exp_sin; angle = 9'd300;
    cyc(1);
    press_start(6);
    cyc(6);
    press_start(6);   // lands while the first run is still in WAIT
    cyc(20);
    @(negedge clk);
    checks++; if (n_starts - s0 !== 1) begin errors++; $display("FAIL lock_nstart got %0d exp 1", n_starts - s0); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL lock_rv got %0b exp 1", result_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_busy got %0b exp 0", busy); end
    press_mode(); @(negedge clk);
    checks++; if (display_number !== exp_cos) begin errors++; $display("FAIL lock_cos got %0d exp %0d", $signed(display_number), $signed(exp_cos)); end
    press_mode(); @(negedge clk);
    checks++; if (display_number !== exp_sin) begin errors++; $display("FAIL lock_sin got %0d exp %0d", $signed(display_number), $signed(exp_sin)); end
    press_mode();
  endtask

  task automatic test_simultaneous();
    int s0;
    s0 = n_starts;
    model_en = 1'b1; model_lat = 3; model_cos = 11'd7; model_sin = 11'd8; angle = 9'd5;
    start_n = 1'b0; mode_n = 1'b0;
    cyc(6);
    start_n = 1'b1; mode_n = 1'b1;
    cyc(20);
    @(negedge clk);
    checks++; if (n_starts - s0 !== 1) begin errors++; $display("FAIL simul_nstart got %0d exp 1", n_starts - s0); end
    checks++; if (display_sel !== 2'd1) begin errors++; $display("FAIL simul_sel got %0d exp 1", display_sel); end
    checks++; if (display_number !== 11'd7) begin errors++; $display("FAIL simul_disp got %0d exp 7", display_number); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL simul_rv got %0b exp 1", result_valid); end
  endtask

  task automatic test_reset_mid();
    bit found;
    model_en = 1'b0; angle = 9'd77;
    cyc(1);
    press_start(6);
    wait_start(found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_start_seen got %0b exp 1", found); end
    cyc(3);
    @(negedge clk);
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL mid_in_wait got %0d exp 2", dbg_state); end
    reset = 1'b1;
    cyc(1);
    reset = 1'b0; man_done = 1'b1;
    cyc(1);
    man_done = 1'b0;
    cyc(3);
    @(negedge clk);
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL mid_state got %0d exp 0", dbg_state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b exp 0", busy); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mid_rv got %0b exp 0", result_valid); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL mid_fault got %0b exp 0", fault); end
    checks++; if (display_number !== 11'd0) begin errors++; $display("FAIL mid_disp got %0d exp 0", display_number); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_timeout();
    test_busy_lockout();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
